// File: rtl/spi_frame_scheduler.sv
// rtl/spi_frame_scheduler.sv - frame sequencer feeding BRAM pixels to the SPI sender one trigger at a time
module spi_frame_scheduler #(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_PIXELS = 57600,
    parameter int ADDR_WIDTH   = $clog2(FRAME_PIXELS),
    parameter int BRAM_LATENCY = 2,
    parameter int GAP_CYCLES   = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic                  abort_in,
    input  logic [DATA_WIDTH-1:0] bram_data_in,
    input  logic                  spi_cs_in,
    output logic [ADDR_WIDTH-1:0] bram_addr_out,
    output logic [DATA_WIDTH-1:0] spi_data_out,
    output logic                  spi_trigger_out,
    output logic                  busy_out,
    output logic                  frame_done_out
);

    localparam int LAT_W = (BRAM_LATENCY > 1) ? $clog2(BRAM_LATENCY) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [LAT_W-1:0]      LAT_LAST  = LAT_W'(BRAM_LATENCY - 1);
    localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_PIXELS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LAUNCH,
        S_WAIT_LOW,
        S_WAIT_HIGH,
        S_GAP
    } state_t;

    state_t                state_q, state_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic [DATA_WIDTH-1:0] data_n;
    logic                  trig_n;
    logic                  busy_n;
    logic                  done_n;
    logic                  abort_q, abort_n;
    logic [LAT_W-1:0]      lat_cnt_q, lat_cnt_n;
    logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_n;
    logic                  end_eval;

    always_comb begin
        state_n   = state_q;
        addr_n    = bram_addr_out;
        data_n    = spi_data_out;
        trig_n    = 1'b0;
        busy_n    = busy_out;
        done_n    = 1'b0;
        abort_n   = abort_q | (abort_in & busy_out);
        lat_cnt_n = lat_cnt_q;
        gap_cnt_n = gap_cnt_q;
        end_eval  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    addr_n    = '0;
                    busy_n    = 1'b1;
                    lat_cnt_n = '0;
                    state_n   = S_FETCH;
                end
            end
            S_FETCH: begin
                if (lat_cnt_q == LAT_LAST) begin
                    data_n  = bram_data_in;
                    trig_n  = 1'b1;
                    state_n = S_LAUNCH;
                end else begin
                    lat_cnt_n = lat_cnt_q + LAT_W'(1);
                end
            end
            S_LAUNCH: begin
                state_n = S_WAIT_LOW;
            end
            // CS is still idle-high right after the trigger; see it fall before waiting for the rise
            S_WAIT_LOW: begin
                if (!spi_cs_in) begin
                    state_n = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (spi_cs_in) begin
                    if (GAP_CYCLES > 0) begin
                        gap_cnt_n = '0;
                        state_n   = S_GAP;
                    end else begin
                        end_eval = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    end_eval = 1'b1;
                end else begin
                    gap_cnt_n = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // Leaving for IDLE always clears the latch so a late abort cannot leak into the next frame
        if (end_eval) begin
            if (abort_q) begin
                state_n = S_IDLE;
                busy_n  = 1'b0;
                addr_n  = '0;
                abort_n = 1'b0;
            end else if (bram_addr_out == LAST_ADDR) begin
                state_n = S_IDLE;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                addr_n  = '0;
                abort_n = 1'b0;
            end else begin
                addr_n    = bram_addr_out + ADDR_WIDTH'(1);
                lat_cnt_n = '0;
                state_n   = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q         <= S_IDLE;
            bram_addr_out   <= '0;
            spi_data_out    <= '0;
            spi_trigger_out <= 1'b0;
            busy_out        <= 1'b0;
            frame_done_out  <= 1'b0;
            abort_q         <= 1'b0;
            lat_cnt_q       <= '0;
            gap_cnt_q       <= '0;
        end else begin
            state_q         <= state_n;
            bram_addr_out   <= addr_n;
            spi_data_out    <= data_n;
            spi_trigger_out <= trig_n;
            busy_out        <= busy_n;
            frame_done_out  <= done_n;
            abort_q         <= abort_n;
            lat_cnt_q       <= lat_cnt_n;
            gap_cnt_q       <= gap_cnt_n;
        end
    end

endmodule

// File: doc/spi_frame_scheduler.md
Name: spi_frame_scheduler

Overview:
Sequences the SPI pixel sender across a full depth frame. It reads pixels one at a time from the frame-buffer BRAM and hands each byte to the sender with a single-cycle trigger. It then waits for the sender to finish, as seen by the sender's chip-select rising, and enforces an inter-pixel gap before fetching the next pixel. It sits between the frame buffer and the SPI sender on the peripheral FPGA and reports frame completion to top-level control.

Parameters:
DATA_WIDTH, 8, pixel width; must equal the sender's data width.
FRAME_PIXELS, 57600, pixels per frame (320x180).
ADDR_WIDTH, $clog2(FRAME_PIXELS), BRAM address width.
BRAM_LATENCY, 2, cycles from address driven to data valid; must be >= 1.
GAP_CYCLES, 4, idle cycles after CS returns high before the next fetch; 0 is legal.

Ports:
clk_in  input  1  system clock (100 MHz)
rst_in  input  1  synchronous, active-high reset
start_in  input  1  begin a frame; honoured only in IDLE
abort_in  input  1  stop after the current pixel; sticky until it takes effect
bram_data_in  input  DATA_WIDTH  frame-buffer read data
spi_cs_in  input  1  sender chip_sel_out; high = idle
bram_addr_out  output  ADDR_WIDTH  frame-buffer read address
spi_data_out  output  DATA_WIDTH  byte to send; held stable from the trigger until the next fetch
spi_trigger_out  output  1  one-cycle pulse starting a sender transaction
busy_out  output  1  high from accepted start until return to IDLE
frame_done_out  output  1  one-cycle pulse after the last pixel's CS rise plus gap

Behaviour:
- Clocking: one clock domain (clk_in). Reset is synchronous and active-high on rst_in.
- Reset values: state=IDLE, bram_addr_out=0, spi_data_out=0, spi_trigger_out=0, busy_out=0, frame_done_out=0, abort latch=0, counters=0.
- Mid-operation reset: rst_in in any state forces the reset values on the next edge. No pulse is emitted.
- Outputs: all registered.
- IDLE:
  - start_in=1 -> bram_addr_out<=0, busy_out<=1, latency counter<=0, go FETCH.
  - start_in=0 -> stay.
  - abort_in while IDLE is ignored and not latched.
- FETCH:
  - Latency counter counts 0..BRAM_LATENCY-1.
  - On the edge where counter==BRAM_LATENCY-1: spi_data_out<=bram_data_in, spi_trigger_out<=1, go LAUNCH.
  - bram_addr_out is stable throughout FETCH.
- LAUNCH (1 cycle): spi_trigger_out<=0, go WAIT_LOW. The trigger is therefore high for exactly one cycle.
- WAIT_LOW: stay until spi_cs_in==0, then go WAIT_HIGH. This guards against sampling the stale idle-high CS.
- WAIT_HIGH: stay until spi_cs_in==1. Then:
  - GAP_CYCLES>0 -> gap counter<=0, go GAP.
  - GAP_CYCLES==0 -> evaluate END directly on the same edge.
- GAP: count 0..GAP_CYCLES-1, then evaluate END.
- END evaluation (priority order):
  1. Abort latch set -> go IDLE: busy_out<=0, bram_addr_out<=0, latch<=0, no frame_done_out.
  2. bram_addr_out==FRAME_PIXELS-1 -> go IDLE: frame_done_out<=1 for one cycle, busy_out<=0, bram_addr_out<=0.
  3. Otherwise -> bram_addr_out<=bram_addr_out+1, latency counter<=0, go FETCH.
- Abort latch: set on any cycle with abort_in=1 while busy_out=1. It is acted on only at END, so an in-flight SPI transaction is never cut short.
- Abort on the last pixel: if abort and last-pixel coincide at END, abort wins and there is no frame_done_out.
- start_in while busy_out=1 is ignored; it is not queued.
- Back-to-back frames: start_in in the cycle frame_done_out is high is seen in IDLE and starts a new frame. Minimum idle between frames is one cycle.
- Address arithmetic: unsigned, ADDR_WIDTH bits. It never wraps because END resets the address before FRAME_PIXELS is reached.
- Per-pixel period: BRAM_LATENCY + 1 (LAUNCH) + WAIT_LOW cycles + sender CS-low duration + GAP_CYCLES + 1.

Test Plan:
Bench config: FRAME_PIXELS=4, BRAM_LATENCY=2, GAP_CYCLES=3, DATA_WIDTH=8. BRAM model returns 0xA0+addr after 2 cycles. Sender model drives CS low 1 cycle after trigger and high 10 cycles later.
- Full frame: start_in pulse -> 4 triggers with spi_data_out 0xA0,0xA1,0xA2,0xA3. Each trigger is exactly 1 cycle wide. Consecutive triggers are spaced by the per-pixel period above. frame_done_out pulses once after the 4th CS rise + 3 gap cycles. busy_out then drops to 0.
- Handshake hold: sender model delays CS rise by 50 cycles on pixel 1 -> no trigger and no address change during the stall. spi_data_out stays 0xA1 until the next fetch.
- Abort: abort_in pulsed 1 cycle during pixel 1's CS-low -> pixel 1 completes, no trigger for 0xA2, return to IDLE, no frame_done_out, bram_addr_out=0.
- Ignored start plus back-to-back: start_in held mid-frame -> exactly 4 triggers. start_in in the frame_done_out cycle -> a second frame starts with 0xA0.
- Reset mid-op: rst_in during WAIT_HIGH of pixel 2 -> next cycle all outputs are at reset values. A following start_in sends 0xA0 first.
- GAP_CYCLES=0 rebuild: CS rise -> next FETCH begins on the following cycle, with no extra idle cycles.
